// File: rtl/mips_pkg.sv
// Shared MIPS encoding constants, request kinds and encoder FSM states.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  typedef enum logic [3:0] {
    K_ADD  = 4'd0,
    K_SUB  = 4'd1,
    K_AND  = 4'd2,
    K_OR   = 4'd3,
    K_SLT  = 4'd4,
    K_LW   = 4'd5,
    K_SW   = 4'd6,
    K_BEQ  = 4'd7,
    K_ADDI = 4'd8,
    K_J    = 4'd9,
    K_END  = 4'd15
  } instr_kind_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCEPT,
    S_WRITE,
    S_DONE
  } enc_state_t;

endpackage

// File: rtl/mips_word_encode.sv
// Combinational request-to-word encoder; END yields no word and is not illegal.
module mips_word_encode
  import mips_pkg::*;
(
  input  logic [3:0]  kind,
  input  logic [4:0]  rs,
  input  logic [4:0]  rt,
  input  logic [4:0]  rd,
  input  logic [15:0] imm,
  input  logic [25:0] target,
  output logic [31:0] word,
  output logic        illegal
);

  always_comb begin
    word    = '0;
    illegal = 1'b0;
    case (kind)
      K_ADD:  word = {OP_RTYPE, rs, rt, rd, 5'd0, FN_ADD};
      K_SUB:  word = {OP_RTYPE, rs, rt, rd, 5'd0, FN_SUB};
      K_AND:  word = {OP_RTYPE, rs, rt, rd, 5'd0, FN_AND};
      K_OR:   word = {OP_RTYPE, rs, rt, rd, 5'd0, FN_OR};
      K_SLT:  word = {OP_RTYPE, rs, rt, rd, 5'd0, FN_SLT};
      K_LW:   word = {OP_LW,   rs, rt, imm};
      K_SW:   word = {OP_SW,   rs, rt, imm};
      K_BEQ:  word = {OP_BEQ,  rs, rt, imm};
      K_ADDI: word = {OP_ADDI, rs, rt, imm};
      K_J:    word = {OP_J, target};
      K_END:  word = '0;
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/mips_instr_encoder.sv
// Accepts symbolic requests and writes encoded MIPS words sequentially into imem.
module mips_instr_encoder
  import mips_pkg::*;
#(
  parameter int ADDR_W    = 6,
  parameter int DEPTH     = 64,
  parameter int BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [3:0]        req_kind,
  input  logic [4:0]        req_rs,
  input  logic [4:0]        req_rt,
  input  logic [4:0]        req_rd,
  input  logic [15:0]       req_imm,
  input  logic [25:0]       req_target,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_waddr,
  output logic [31:0]       imem_wdata,
  output logic [ADDR_W:0]   words_written,
  output logic              done,
  output logic              full,
  output logic              err_illegal
);

  localparam logic [ADDR_W:0]   DEPTH_W = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] BASE_W  = ADDR_W'(BASE_ADDR);

  enc_state_t        state;
  logic [ADDR_W-1:0] ptr;
  logic [31:0]       enc_word;
  logic              enc_illegal;
  logic              hs;

  assign hs = req_valid && req_ready;

  mips_word_encode u_enc (
    .kind    (req_kind),
    .rs      (req_rs),
    .rt      (req_rt),
    .rd      (req_rd),
    .imm     (req_imm),
    .target  (req_target),
    .word    (enc_word),
    .illegal (enc_illegal)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= S_IDLE;
      ptr           <= '0;
      req_ready     <= 1'b0;
      imem_we       <= 1'b0;
      imem_waddr    <= '0;
      imem_wdata    <= '0;
      words_written <= '0;
      done          <= 1'b0;
      full          <= 1'b0;
      err_illegal   <= 1'b0;
    end else begin
      imem_we <= 1'b0;
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            state         <= S_ACCEPT;
            req_ready     <= 1'b1;
            ptr           <= BASE_W;
            words_written <= '0;
            done          <= 1'b0;
            full          <= 1'b0;
            err_illegal   <= 1'b0;
          end
        end
        S_ACCEPT: begin
          if (hs) begin
            if (req_kind == K_END) begin
              state     <= S_DONE;
              req_ready <= 1'b0;
              done      <= 1'b1;
            end else if (enc_illegal) begin
              err_illegal <= 1'b1;
            end else begin
              // The word register doubles as the capture register for the request.
              state      <= S_WRITE;
              req_ready  <= 1'b0;
              imem_we    <= 1'b1;
              imem_waddr <= ptr;
              imem_wdata <= enc_word;
            end
          end
        end
        S_WRITE: begin
          ptr           <= ptr + 1'b1;
          words_written <= words_written + 1'b1;
          if (words_written + 1'b1 == DEPTH_W) begin
            state <= S_DONE;
            full  <= 1'b1;
            done  <= 1'b1;
          end else begin
            state     <= S_ACCEPT;
            req_ready <= 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mips_instr_encoder.sv
// Directed plus randomized check of mips_instr_encoder against a field-arithmetic model.
module tb_mips_instr_encoder;

  localparam int ADDR_W = 4;
  localparam int DEPTH  = 8;
  localparam int BASE   = 0;

  logic              clk = 1'b0;
  logic              reset, start, req_valid, req_ready;
  logic [3:0]        req_kind;
  logic [4:0]        req_rs, req_rt, req_rd;
  logic [15:0]       req_imm;
  logic [25:0]       req_target;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_waddr;
  logic [31:0]       imem_wdata;
  logic [ADDR_W:0]   words_written;
  logic              done, full, err_illegal;

  int checks = 0;
  int errors = 0;

  // reference model state
  int          m_ptr, m_count;
  logic        m_done, m_full, m_err;
  logic [31:0] last_wdata;

  always #5 clk = ~clk;

  mips_instr_encoder #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .BASE_ADDR(BASE)) dut (
    .clk(clk), .reset(reset), .start(start),
    .req_valid(req_valid), .req_ready(req_ready), .req_kind(req_kind),
    .req_rs(req_rs), .req_rt(req_rt), .req_rd(req_rd),
    .req_imm(req_imm), .req_target(req_target),
    .imem_we(imem_we), .imem_waddr(imem_waddr), .imem_wdata(imem_wdata),
    .words_written(words_written), .done(done), .full(full),
    .err_illegal(err_illegal)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Word built as a sum of field values times their bit weights.
  function automatic logic [31:0] model_word(input int k, input int rs, input int rt,
                                             input int rd, input int imm, input int tgt);
    longint op, fn, w;
    op = 0; fn = 0; w = 0;
    if (k <= 4) begin
      case (k)
        0: fn = 32; 1: fn = 34; 2: fn = 36; 3: fn = 37; default: fn = 42;
      endcase
      w = rs * 64'd2097152 + rt * 64'd65536 + rd * 64'd2048 + fn;
    end else if (k <= 8) begin
      case (k)
        5: op = 35; 6: op = 43; 7: op = 4; default: op = 8;
      endcase
      w = op * 64'd67108864 + rs * 64'd2097152 + rt * 64'd65536 + imm;
    end else begin
      w = 2 * 64'd67108864 + tgt;
    end
    return w[31:0];
  endfunction

  task automatic do_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    m_ptr = BASE; m_count = 0; m_done = 0; m_full = 0; m_err = 0;
    chk("start_ready", {31'd0, req_ready}, 32'd1);
    chk("start_ww", {27'd0, words_written}, 32'd0);
    chk("start_flags", {29'd0, done, full, err_illegal}, 32'd0);
  endtask

  // Called at a negedge; issues one request and checks the resulting cycles.
  task automatic do_req(input int k, input int rs, input int rt, input int rd,
                        input int imm, input int tgt);
    int cyc;
    req_kind = 4'(k); req_rs = 5'(rs); req_rt = 5'(rt); req_rd = 5'(rd);
    req_imm = 16'(imm); req_target = 26'(tgt);
    req_valid = 1'b1;
    cyc = 0;
    while (req_ready !== 1'b1 && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    if (cyc >= 20) begin
      chk("ready_timeout", 32'd0, 32'd1);
      req_valid = 1'b0;
      return;
    end
    @(negedge clk);
    req_valid = 1'b0;
    if (k <= 9) begin
      chk("wr_we", {31'd0, imem_we}, 32'd1);
      chk("wr_addr", {28'd0, imem_waddr}, 32'(m_ptr));
      chk("wr_data", imem_wdata, model_word(k, rs, rt, rd, imm, tgt));
      chk("wr_ready_low", {31'd0, req_ready}, 32'd0);
      last_wdata = imem_wdata;
      @(negedge clk);
      m_ptr++; m_count++;
      if (m_count == DEPTH) begin m_full = 1; m_done = 1; end
      chk("post_we", {31'd0, imem_we}, 32'd0);
      chk("post_ww", {27'd0, words_written}, 32'(m_count));
      chk("post_done_full", {30'd0, done, full}, {30'd0, m_done, m_full});
      chk("post_ready", {31'd0, req_ready}, {31'd0, !m_done});
    end else if (k == 15) begin
      m_done = 1;
      chk("end_we", {31'd0, imem_we}, 32'd0);
      chk("end_done", {31'd0, done}, 32'd1);
      chk("end_ready", {31'd0, req_ready}, 32'd0);
      chk("end_ww", {27'd0, words_written}, 32'(m_count));
    end else begin
      m_err = 1;
      chk("ill_we", {31'd0, imem_we}, 32'd0);
      chk("ill_err", {31'd0, err_illegal}, 32'd1);
      chk("ill_ready", {31'd0, req_ready}, 32'd1);
    end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; req_valid = 1'b0; req_kind = '0;
    req_rs = '0; req_rt = '0; req_rd = '0; req_imm = '0; req_target = '0;
    m_ptr = 0; m_count = 0; m_done = 0; m_full = 0; m_err = 0; last_wdata = '0;
    @(negedge clk); @(negedge clk);
    chk("rst_outputs", {req_ready, imem_we, imem_waddr, words_written, done, full, err_illegal},
        '0);
    chk("rst_wdata", imem_wdata, 32'd0);
    reset = 1'b0;

    // idle ignores requests until start
    req_valid = 1'b1;
    repeat (3) @(negedge clk);
    chk("idle_ready", {30'd0, req_ready, imem_we}, 32'd0);
    req_valid = 1'b0;

    // directed encodings
    do_start();
    do_req(0, 1, 2, 3, 0, 0);       chk("lit_add",  last_wdata, 32'h00221820);
    do_req(5, 0, 2, 0, 4, 0);       chk("lit_lw",   last_wdata, 32'h8C020004);
    do_req(6, 0, 2, 0, 8, 0);       chk("lit_sw",   last_wdata, 32'hAC020008);
    do_req(7, 1, 2, 0, 16'hFFFF, 0); chk("lit_beq", last_wdata, 32'h1022FFFF);
    do_req(8, 0, 1, 0, 5, 0);       chk("lit_addi", last_wdata, 32'h20010005);
    // start raised alongside a handshake must be ignored
    start = 1'b1;
    do_req(9, 7, 7, 7, 3, 32'h10);
    start = 1'b0;
    chk("lit_j", last_wdata, 32'h08000010);
    do_req(15, 0, 0, 0, 0, 0);
    // data and address hold after the last write
    chk("hold_wdata", imem_wdata, 32'h08000010);
    chk("hold_waddr", {28'd0, imem_waddr}, 32'd5);

    // illegal then END: nothing written, sticky error
    do_start();
    do_req(12, 1, 1, 1, 1, 1);
    do_req(15, 0, 0, 0, 0, 0);
    chk("ill_sticky", {31'd0, err_illegal}, 32'd1);
    chk("ill_ww", {27'd0, words_written}, 32'd0);

    // randomized programs
    for (int p = 0; p < 4; p++) begin
      do_start();
      for (int n = 0; n < 12 && !m_done; n++)
        do_req($urandom_range(0, 15), $urandom_range(0, 31), $urandom_range(0, 31),
               $urandom_range(0, 31), $urandom_range(0, 65535), $urandom & 32'h3FFFFFF);
      chk("rand_err", {31'd0, err_illegal}, {31'd0, m_err});
    end

    // fill memory, then a held request is never accepted
    do_start();
    while (!m_done) do_req(0, 1, 2, 3, 0, 0);
    req_kind = 4'd0; req_valid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("full_hold", {29'd0, req_ready, imem_we, full}, 32'd1);
    end
    req_valid = 1'b0;
    chk("full_ww", {27'd0, words_written}, 32'(DEPTH));

    // reset coincident with a handshake edge suppresses the write
    do_start();
    req_kind = 4'd1; req_valid = 1'b1; reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("rst_we", {31'd0, imem_we}, 32'd0);
    chk("rst_all", {req_ready, imem_waddr, words_written, done, full, err_illegal}, '0);
    chk("rst_wdata2", imem_wdata, 32'd0);
    repeat (3) @(negedge clk);
    chk("rst_idle", {30'd0, req_ready, imem_we}, 32'd0);
    req_valid = 1'b0;
    do_start();
    do_req(1, 4, 5, 6, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
